// File: rtl/eq_pkg.sv
// Shared sizes and controller state encoding for the EQ FIR sequencer.
// These defaults are also used by the later gain stages.
package eq_pkg;
   localparam int ORDER      = 12;
   localparam int SAMPLE_W   = 24;
   localparam int COEF_W     = 16;
   localparam int ACC_W      = 44;
   localparam int FRAC_SHIFT = 15;
   localparam int TIMEOUT    = 64;

   typedef enum logic [2:0] {
      IDLE,
      SWAP,
      START,
      WAIT,
      OUT
   } eq_ctrl_state_t;
endpackage

// File: rtl/eq_round_sat.sv
// Round-half-up arithmetic shift of a wide accumulator, then clip to the sample range.
// Purely combinational: zero latency, no handshake.
module eq_round_sat #(
   parameter int ACC_W      = 44,
   parameter int SAMPLE_W   = 24,
   parameter int FRAC_SHIFT = 15
) (
   input  logic [ACC_W-1:0]    acc,
   output logic [SAMPLE_W-1:0] res,
   output logic                clip
);
   localparam int W = ACC_W + 1;
   localparam logic [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

   logic signed [W-1:0] biased;
   logic signed [W-1:0] shifted;
   logic                fits;

   // One guard bit keeps the +half bias from wrapping at the top of the range.
   assign biased  = $signed({acc[ACC_W-1], acc}) + $signed(HALF);
   assign shifted = biased >>> FRAC_SHIFT;

   // In range when every bit above the sample sign bit copies it.
   assign fits = (&shifted[W-1:SAMPLE_W-1]) | ~(|shifted[W-1:SAMPLE_W-1]);
   assign clip = ~fits;

   always_comb begin
      res = shifted[SAMPLE_W-1:0];
      if (!fits) begin
         res = shifted[W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
      end
   end
endmodule

// File: rtl/eq_filter_ctrl.sv
// Sequences one filter run per accepted sample, manages shadow/active coefficient banks.
// Latency >= 3 cycles sample-to-result; one sample in flight, o_sample_ready low while busy.
module eq_filter_ctrl
   import eq_pkg::*;
(
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [SAMPLE_W-1:0]       i_sample,
   input  logic                      i_sample_valid,
   output logic                      o_sample_ready,
   input  logic [3:0]                i_coef_addr,
   input  logic [COEF_W-1:0]         i_coef_data,
   input  logic                      i_coef_we,
   input  logic                      i_coef_commit,
   output logic                      o_commit_pending,
   output logic [SAMPLE_W-1:0]       o_filt_sample,
   output logic [ORDER*COEF_W-1:0]   o_filt_coefs,
   output logic                      o_filt_start,
   input  logic [ACC_W-1:0]          i_filt_result,
   input  logic                      i_filt_ready,
   output logic [SAMPLE_W-1:0]       o_result,
   output logic                      o_result_valid,
   input  logic                      i_result_ready,
   output logic                      o_timeout,
   output logic                      o_sat,
   input  logic                      i_clear_err
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   eq_ctrl_state_t                  state, state_d;
   logic                            alive;
   logic                            pending;
   logic [ORDER-1:0][COEF_W-1:0]    shadow;
   logic [ORDER-1:0][COEF_W-1:0]    active;
   logic [CNT_W-1:0]                wait_cnt;
   logic [SAMPLE_W-1:0]             rs_res;
   logic                            rs_clip;
   logic                            accept;
   logic                            wait_last;
   logic                            wait_hit;
   logic                            wait_expired;

   eq_round_sat #(
      .ACC_W      (ACC_W),
      .SAMPLE_W   (SAMPLE_W),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_round_sat (
      .acc  (i_filt_result),
      .res  (rs_res),
      .clip (rs_clip)
   );

   assign wait_last        = (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign accept           = o_sample_ready & i_sample_valid;
   assign wait_hit         = (state == WAIT) & i_filt_ready;
   assign wait_expired     = (state == WAIT) & ~i_filt_ready & wait_last;
   assign o_commit_pending = pending;
   assign o_filt_coefs     = active;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d        = state;
      o_sample_ready = 1'b0;
      o_filt_start   = 1'b0;
      o_result_valid = 1'b0;
      case (state)
         IDLE: begin
            // alive holds ready low for the first cycle after reset release
            o_sample_ready = alive & ~pending;
            if (alive & ~pending & i_sample_valid) begin
               state_d = START;
            end else if (pending | i_coef_commit) begin
               state_d = SWAP;
            end
         end
         SWAP: begin
            state_d = IDLE;
         end
         START: begin
            o_filt_start = 1'b1;
            state_d      = WAIT;
         end
         WAIT: begin
            if (i_filt_ready) begin
               state_d = OUT;
            end else if (wait_last) begin
               state_d = IDLE;
            end
         end
         OUT: begin
            o_result_valid = 1'b1;
            if (i_result_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         alive         <= 1'b0;
         pending       <= 1'b0;
         shadow        <= '0;
         active        <= '0;
         wait_cnt      <= '0;
         o_filt_sample <= '0;
         o_result      <= '0;
         o_timeout     <= 1'b0;
         o_sat         <= 1'b0;
      end else begin
         alive <= 1'b1;

         for (int i = 0; i < ORDER; i++) begin
            if (i_coef_we && (i_coef_addr == 4'(i))) begin
               shadow[i] <= i_coef_data;
            end
         end

         // The swap copies the shadow as it stood before this cycle's write.
         if (state == SWAP) begin
            active  <= shadow;
            pending <= 1'b0;
         end else if (i_coef_commit) begin
            pending <= 1'b1;
         end

         if (accept) begin
            o_filt_sample <= i_sample;
         end

         if (state == START) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (wait_hit) begin
            o_result <= rs_res;
         end

         if (wait_hit & rs_clip) begin
            o_sat <= 1'b1;
         end else if (i_clear_err) begin
            o_sat <= 1'b0;
         end

         if (wait_expired) begin
            o_timeout <= 1'b1;
         end else if (i_clear_err) begin
            o_timeout <= 1'b0;
         end
      end
   end
endmodule
